// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, defaults and delay helpers for the systolic array sequencer
package systolic_pkg;
  localparam int N_DEF = 4;
  localparam int DRAIN_MULT = 4;
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;
  function automatic int drain_len(input int n);
    return DRAIN_MULT * n;
  endfunction
  // Issue flag to column j bottom: 1 edge register, 2 per PE row, plus the 2j column skew
  function automatic int res_delay(input int n, input int j);
    return 2 * n + 2 * j + 1;
  endfunction
endpackage

// File: rtl/skew_delay.sv
// skew_delay: DEPTH-stage WIDTH-bit shift register, asynchronously cleared to zero
// Ports: CLK clock; RSTN async active-low reset; d shift-in value; q value delayed DEPTH cycles.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d[0] = d;
    for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-load and skewed activation-stream sequencer for an NxN weight-stationary systolic array
// Ports: CLK/RSTN clock and async active-low reset; START/SKIP_W/VEC_CNT job request;
//   BUSY/DONE job status; W_ADDR/W_RDATA/W_LOAD/W_BUS weight buffer read and per-row load strobe;
//   A_ADDR/A_RDATA activation buffer read; A_EDGE/EN_LEFT/EN_TOP/RES_VALID skewed array edge signals.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int AW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic            SKIP_W,
  input  logic [7:0]      VEC_CNT,
  output logic            BUSY,
  output logic            DONE,
  output logic [AW-1:0]   W_ADDR,
  input  logic [N*8-1:0]  W_RDATA,
  output logic [N-1:0]    W_LOAD,
  output logic [N*8-1:0]  W_BUS,
  output logic [7:0]      A_ADDR,
  input  logic [N*8-1:0]  A_RDATA,
  output logic [N*8-1:0]  A_EDGE,
  output logic [N-1:0]    EN_LEFT,
  output logic [N-1:0]    EN_TOP,
  output logic [N-1:0]    RES_VALID
);
  localparam logic [7:0] LAST_W = 8'(N - 1);
  localparam logic [7:0] DRAIN_END = 8'(drain_len(N));
  localparam logic [N-1:0] ROW0 = {{(N-1){1'b0}}, 1'b1};
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, m_q, m_d;
  logic issue_q, issue_d;
  logic [N-1:0] w_load_q, w_load_d;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      issue_q  <= 1'b0;
      w_load_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      issue_q  <= issue_d;
      w_load_q <= w_load_d;
    end
  // DRAIN counts one past its 4N cycles: that extra cycle is the DONE cycle, still in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 8'd1;
    m_d = m_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (START && VEC_CNT != 8'd0) begin
          m_d = VEC_CNT;
          state_d = SKIP_W ? STREAM : LOAD_W;
        end
      end
      LOAD_W: if (cnt_q == LAST_W) begin
        state_d = STREAM;
        cnt_d = '0;
      end
      STREAM: if (cnt_q == m_q - 8'd1) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: if (cnt_q == DRAIN_END) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Read data lags its address by one cycle, so the load strobe and issue flag are registered to match
  always_comb begin
    DONE = state_q == DRAIN && cnt_q == DRAIN_END;
    BUSY = state_q != IDLE && !DONE;
    W_ADDR = state_q == LOAD_W ? cnt_q[AW-1:0] : '0;
    A_ADDR = state_q == STREAM ? cnt_q : '0;
    w_load_d = state_q == LOAD_W ? ROW0 << cnt_q[AW-1:0] : '0;
    issue_d = state_q == STREAM;
  end
  assign W_LOAD = w_load_q;
  assign W_BUS = W_RDATA;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [8:0] row_d;
    assign row_d = issue_q ? {1'b1, A_RDATA[8*i+:8]} : 9'd0;
    skew_delay #(.DEPTH(1 + 2 * i), .WIDTH(9)) u_row (
      .CLK(CLK), .RSTN(RSTN), .d(row_d), .q({EN_LEFT[i], A_EDGE[8*i+:8]})
    );
    skew_delay #(.DEPTH(1 + 2 * i), .WIDTH(1)) u_top (
      .CLK(CLK), .RSTN(RSTN), .d(issue_q), .q(EN_TOP[i])
    );
    skew_delay #(.DEPTH(res_delay(N, i)), .WIDTH(1)) u_res (
      .CLK(CLK), .RSTN(RSTN), .d(issue_q), .q(RES_VALID[i])
    );
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed bench for systolic_ctrl driving a 4x4 PE grid from 1-cycle-latency buffer models
module tb_systolic_ctrl;
  localparam int N = 4;
  localparam int AW = 2;
  logic CLK = 1'b0, RSTN = 1'b0, START = 1'b0, SKIP_W = 1'b0;
  logic [7:0] VEC_CNT = '0;
  logic BUSY, DONE;
  logic [AW-1:0] W_ADDR;
  logic [N*8-1:0] W_RDATA, W_BUS, A_RDATA, A_EDGE;
  logic [N-1:0] W_LOAD, EN_LEFT, EN_TOP, RES_VALID;
  logic [7:0] A_ADDR;
  logic [N*8-1:0] w_mem [N];
  logic [N*8-1:0] a_mem [256];
  logic [15:0] exp_res [8][N];
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  systolic_ctrl #(.N(N)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .SKIP_W(SKIP_W), .VEC_CNT(VEC_CNT),
    .BUSY(BUSY), .DONE(DONE), .W_ADDR(W_ADDR), .W_RDATA(W_RDATA), .W_LOAD(W_LOAD),
    .W_BUS(W_BUS), .A_ADDR(A_ADDR), .A_RDATA(A_RDATA), .A_EDGE(A_EDGE),
    .EN_LEFT(EN_LEFT), .EN_TOP(EN_TOP), .RES_VALID(RES_VALID)
  );

  always @(posedge CLK) begin
    W_RDATA <= w_mem[W_ADDR];
    A_RDATA <= a_mem[A_ADDR];
  end

  // PE grid: activation moves right and partial sum moves down, each through 2 registers per PE
  logic signed [7:0] wt [N][N];
  logic signed [7:0] a_s1 [N][N];
  logic signed [7:0] a_o [N][N];
  logic e_s1 [N][N];
  logic e_o [N][N];
  logic [15:0] p_s1 [N][N];
  logic [15:0] p_o [N][N];

  function automatic logic signed [7:0] a_in(int i, int j);
    if (j == 0) return $signed(A_EDGE[8*i+:8]);
    return a_o[i][j-1];
  endfunction
  function automatic logic e_in(int i, int j);
    if (j == 0) return EN_LEFT[i];
    return e_o[i][j-1];
  endfunction
  function automatic logic [15:0] p_in(int i, int j);
    if (i == 0) return 16'h0;
    return p_o[i-1][j];
  endfunction
  function automatic logic [15:0] mac(int i, int j);
    logic signed [15:0] r;
    r = wt[i][j] * a_in(i, j);
    return e_in(i, j) ? p_in(i, j) + r : p_in(i, j);
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (W_LOAD[i]) wt[i][j] <= $signed(W_BUS[8*j+:8]);
        if (!RSTN) begin
          a_s1[i][j] <= '0; a_o[i][j] <= '0;
          e_s1[i][j] <= 1'b0; e_o[i][j] <= 1'b0;
          p_s1[i][j] <= '0; p_o[i][j] <= '0;
        end else begin
          a_s1[i][j] <= e_in(i, j) ? a_in(i, j) : 8'sd0;
          e_s1[i][j] <= e_in(i, j);
          p_s1[i][j] <= mac(i, j);
          a_o[i][j] <= a_s1[i][j];
          e_o[i][j] <= e_s1[i][j];
          p_o[i][j] <= p_s1[i][j];
        end
      end
  end

  // START is cycle 0; cycle k is observed at the negedge k cycles later
  task automatic run_job(input string name, input bit skip, input int m, input int junk);
    int s, dn, mi;
    logic [27:0] e_ctl, g_ctl;
    logic [N-1:0] e_wl, e_el, e_rv;
    logic [AW-1:0] e_wa;
    logic [7:0] e_aa;
    logic [N*8-1:0] e_ae;
    s = skip ? 1 : N + 1;
    dn = s + m + 4 * N;
    @(negedge CLK);
    START = 1'b1; SKIP_W = skip; VEC_CNT = 8'(m);
    for (int k = 1; k <= dn + 2; k++) begin
      @(negedge CLK);
      START = junk != 0 && (k == junk || k == dn);
      SKIP_W = 1'b0;
      VEC_CNT = 8'd5;
      e_wl = (!skip && k >= 2 && k <= N + 1) ? 4'(1 << (k - 2)) : '0;
      e_wa = (!skip && k <= N) ? AW'(k - 1) : '0;
      e_aa = (k >= s && k < s + m) ? 8'(k - s) : '0;
      e_el = '0; e_ae = '0; e_rv = '0;
      for (int i = 0; i < N; i++) begin
        mi = k - s - 2 - 2 * i;
        if (mi >= 0 && mi < m) begin
          e_el[i] = 1'b1;
          e_ae[8*i+:8] = a_mem[mi][8*i+:8];
        end
        mi = k - s - 2 * N - 2 * i - 2;
        if (mi >= 0 && mi < m) begin
          e_rv[i] = 1'b1;
          n_chk++;
          if (p_o[N-1][i] !== exp_res[mi][i]) begin
            n_fail++;
            $display("FAIL %s col%0d_result k=%0d vec=%0d got %h exp %h", name, i, k, mi, p_o[N-1][i], exp_res[mi][i]);
          end
        end
      end
      e_ctl = {k < dn, k == dn, e_wl, e_wa, e_aa, e_el, e_el, e_rv};
      g_ctl = {BUSY, DONE, W_LOAD, W_ADDR, A_ADDR, EN_LEFT, EN_TOP, RES_VALID};
      n_chk++;
      if (g_ctl !== e_ctl) begin
        n_fail++;
        $display("FAIL %s ctl{busy,done,wload,waddr,aaddr,enl,ent,rv} k=%0d got %h exp %h", name, k, g_ctl, e_ctl);
      end
      n_chk++;
      if (A_EDGE !== e_ae) begin
        n_fail++;
        $display("FAIL %s a_edge k=%0d got %h exp %h", name, k, A_EDGE, e_ae);
      end
      n_chk++;
      if (W_BUS !== W_RDATA) begin
        n_fail++;
        $display("FAIL %s w_bus k=%0d got %h exp %h", name, k, W_BUS, W_RDATA);
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    n_chk++;
    if ({BUSY, DONE, W_LOAD, W_ADDR, A_ADDR, EN_LEFT, EN_TOP, RES_VALID, A_EDGE} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got %h exp 0", {BUSY, DONE, W_LOAD, W_ADDR, A_ADDR, EN_LEFT, EN_TOP, RES_VALID, A_EDGE});
    end
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < N; i++) w_mem[i] = 32'h1 << (8 * i);
    a_mem[0] = 32'h04030201; a_mem[1] = 32'h05050505; a_mem[2] = 32'h07070707;
    @(negedge CLK);
    START = 1'b1; SKIP_W = 1'b0; VEC_CNT = 8'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    RSTN = 1'b0;
    #1;
    n_chk++;
    if ({BUSY, DONE, W_LOAD, W_ADDR, A_ADDR, EN_LEFT, EN_TOP, RES_VALID, A_EDGE} !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset got %h exp 0", {BUSY, DONE, W_LOAD, W_ADDR, A_ADDR, EN_LEFT, EN_TOP, RES_VALID, A_EDGE});
    end
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      n_chk++;
      if ({BUSY, DONE, RES_VALID} !== '0) begin
        n_fail++;
        $display("FAIL after_reset_quiet k=%0d got %h exp 0", k, {BUSY, DONE, RES_VALID});
      end
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) w_mem[i] = 32'h1 << (8 * i);
    a_mem[0] = 32'h04030201;
    for (int j = 0; j < N; j++) exp_res[0][j] = 16'(j + 1);
    run_job("identity", 1'b0, 1, 0);
  endtask

  task automatic set_all2();
    for (int i = 0; i < N; i++) w_mem[i] = 32'h02020202;
    a_mem[0] = 32'h01010101; a_mem[1] = 32'hFCFDFEFF; a_mem[2] = 32'h7F7F7F7F;
    for (int j = 0; j < N; j++) begin
      exp_res[0][j] = 16'd8; exp_res[1][j] = 16'hFFEC; exp_res[2][j] = 16'd1016;
    end
  endtask

  task automatic test_all2();
    set_all2();
    run_job("all2", 1'b0, 3, 0);
  endtask

  task automatic test_skip();
    run_job("skip_w", 1'b1, 3, 0);
  endtask

  task automatic test_neg128();
    for (int i = 0; i < N; i++) w_mem[i] = 32'h80808080;
    a_mem[0] = 32'h80808080;
    for (int j = 0; j < N; j++) exp_res[0][j] = 16'h0000;
    run_job("neg128", 1'b0, 1, 0);
  endtask

  task automatic test_ignored_start();
    @(negedge CLK);
    START = 1'b1; SKIP_W = 1'b0; VEC_CNT = 8'd0;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({BUSY, DONE} !== 2'b00) begin
        n_fail++;
        $display("FAIL vec0_start k=%0d got %b exp 00", k, {BUSY, DONE});
      end
      @(negedge CLK);
    end
    set_all2();
    run_job("busy_start", 1'b0, 2, 6);
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_identity();
    test_all2();
    test_skip();
    test_neg128();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
